// File: rtl/mmio_responder_pkg.sv
// Shared register map, STATUS bit positions and address-region default for the MMIO responder.
package mmio_responder_pkg;

    localparam logic [2:0] MMIO_TXDATA  = 3'd0;
    localparam logic [2:0] MMIO_STATUS  = 3'd1;
    localparam logic [2:0] MMIO_CYCLE   = 3'd2;
    localparam logic [2:0] MMIO_INSTRET = 3'd3;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 4;

    localparam logic [3:0] MMIO_BASE_NIBBLE = 4'h8;

    function automatic logic [7:0] status_byte(input logic full, input logic empty,
                                               input logic ovf, input logic [3:0] count);
        status_byte = 8'h00;
        status_byte[STATUS_FULL]                = full;
        status_byte[STATUS_EMPTY]               = empty;
        status_byte[STATUS_OVF]                 = ovf;
        status_byte[STATUS_COUNT_LSB +: 4]      = count;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push is accepted when not full or when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head is zeroed while empty so a reset blanks the output without clearing storage.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target: TX byte FIFO, free-running cycle counter and retired-instruction counter.
// tx handshake: a byte transfers on any rising edge where tx_valid & tx_ready are both high.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [3:0] BASE_NIBBLE = MMIO_BASE_NIBBLE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] mem_adr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [3:0]      wea,
    input  logic            instr_retired,
    output logic [XLEN-1:0] din,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            sel;
    logic [2:0]      offset;
    logic            wr_en;
    logic            rd_en;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     count_ext;
    logic [3:0]      count_disp;
    logic            ovf;
    logic            ovf_set;
    logic            ovf_clr;
    logic [XLEN-1:0] cycle_cnt;
    logic [XLEN-1:0] instret_cnt;
    logic [XLEN-1:0] rd_value;
    logic            unused_bits;

    assign sel    = (mem_adr[31:28] == BASE_NIBBLE);
    assign offset = mem_adr[4:2];
    assign wr_en  = sel & (wea != 4'b0000);
    assign rd_en  = sel & (wea == 4'b0000);

    assign push     = wr_en & (offset == MMIO_TXDATA) & wea[0];
    assign pop      = tx_valid & tx_ready;
    assign tx_valid = ~fifo_empty;
    assign ovf_set  = push & fifo_full & ~pop;
    assign ovf_clr  = wr_en & (offset == MMIO_STATUS) & wea[0] & mem_wdata[STATUS_OVF];

    assign count_ext  = 32'(fifo_count);
    assign count_disp = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    assign unused_bits = ^{mem_adr[27:5], mem_adr[1:0], mem_wdata[XLEN-1:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (mem_wdata[7:0]),
        .rdata (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Clear has priority over the same-cycle increment on both counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (wr_en && offset == MMIO_CYCLE) cycle_cnt <= '0;
            else                               cycle_cnt <= cycle_cnt + XLEN'(1);
            if (wr_en && offset == MMIO_INSTRET) instret_cnt <= '0;
            else if (instr_retired)              instret_cnt <= instret_cnt + XLEN'(1);
        end
    end

    always_comb begin
        rd_value = '0;
        case (offset)
            MMIO_STATUS:  rd_value = XLEN'(status_byte(fifo_full, fifo_empty, ovf, count_disp));
            MMIO_CYCLE:   rd_value = cycle_cnt;
            MMIO_INSTRET: rd_value = instret_cnt;
            default:      rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      din <= '0;
        else if (rd_en) din <= rd_value;
        else            din <= '0;
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with queued expectations checked by a negedge monitor.
module tb_mmio_responder;

    localparam logic [31:0] A_TX    = 32'h8000_0000;
    localparam logic [31:0] A_STAT  = 32'h8000_0004;
    localparam logic [31:0] A_CYC   = 32'h8000_0008;
    localparam logic [31:0] A_INST  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_adr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  wea = '0;
    logic        instr_retired = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] din;
    logic [7:0]  tx_data;
    logic        tx_valid;

    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic        rd_req = 1'b0;
    logic        rd_pending = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] tb_cyc;
    logic [31:0] clr_mark = '0;

    mmio_responder dut (
        .clk           (clk),
        .reset         (reset),
        .mem_adr       (mem_adr),
        .mem_wdata     (mem_wdata),
        .wea           (wea),
        .instr_retired (instr_retired),
        .din           (din),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endfunction

    // driver tasks: each call occupies one clock cycle
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         input logic ir, input logic rdy, input logic is_rd);
        @(posedge clk);
        #2;
        mem_adr = a; mem_wdata = d; wea = w; instr_retired = ir; tx_ready = rdy; rd_req = is_rd;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic rdy);
        drive(a, 32'h0, 4'b0000, 1'b0, rdy, 1'b1);
        exp_q.push_back(exp);
    endtask

    task automatic rd_cycle();
        drive(A_CYC, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(tb_cyc - clr_mark);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                      input logic ir, input logic rdy);
        drive(a, d, w, ir, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 4'b0000, 1'b0, rdy, 1'b0);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted, input logic rdy);
        wr(A_TX, {24'h0, b}, 4'b0001, 1'b0, rdy);
        if (accepted) tx_q.push_back(b);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (!tx_valid) break;
        end
        check("tx_drain", {31'h0, tx_valid}, 32'h0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            tx_q.delete();
            rd_pending = 1'b0;
        end else begin
            if (rd_pending) begin
                if (exp_q.size() == 0) check("din_unexpected", din, 32'hxxxx_xxxx);
                else                   check("din", din, exp_q.pop_front());
            end
            rd_pending = rd_req;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hxxxx_xxxx);
                else                  check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_din", din, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        clr_mark = '0;

        // idle then read the cycle counter
        idle(10, 1'b0);
        rd_cycle();
        #1;
        check("idle_tx_valid", {31'h0, tx_valid}, 32'h0);

        // three bytes queued, then drained
        push_byte(8'h41, 1, 1'b0);
        push_byte(8'h42, 1, 1'b0);
        push_byte(8'h43, 1, 1'b0);
        rd(A_STAT, 32'h0000_0030, 1'b0);
        idle(1, 1'b1);
        wait_drain(10);
        idle(1, 1'b0);

        // overflow on the ninth push, then clear it
        for (int i = 1; i <= 9; i++) push_byte(8'(i), i <= 8, 1'b0);
        rd(A_STAT, 32'h0000_0085, 1'b0);
        wr(A_STAT, 32'h0000_0004, 4'b0001, 1'b0, 1'b0);
        rd(A_STAT, 32'h0000_0081, 1'b0);

        // push into a full FIFO while popping
        push_byte(8'h55, 1, 1'b1);
        rd(A_STAT, 32'h0000_0081, 1'b0);
        idle(1, 1'b1);
        wait_drain(20);
        idle(1, 1'b0);
        rd(A_STAT, 32'h0000_0002, 1'b0);
        rd(A_TX, 32'h0, 1'b0);
        rd(32'h8000_0010, 32'h0, 1'b0);

        // retired-instruction counter, clear beats a same-cycle pulse
        for (int i = 0; i < 5; i++) drive(32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rd(A_INST, 32'd5, 1'b0);
        wr(A_INST, 32'h0, 4'b1111, 1'b1, 1'b0);
        rd(A_INST, 32'd0, 1'b0);
        drive(32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rd(A_INST, 32'd1, 1'b0);

        // unselected writes do nothing; selected write clears CYCLE
        wr(32'h9000_0008, 32'h0, 4'b1111, 1'b0, 1'b0);
        wr(32'h9000_0000, 32'h77, 4'b0001, 1'b0, 1'b0);
        rd_cycle();
        rd(A_STAT, 32'h0000_0002, 1'b0);
        wr(A_CYC, 32'h0, 4'b1000, 1'b0, 1'b0);
        clr_mark = tb_cyc + 32'd1;
        idle(3, 1'b0);
        rd_cycle();
        idle(1, 1'b0);

        // reset mid-drain
        push_byte(8'hA1, 1, 1'b0);
        push_byte(8'hA2, 1, 1'b0);
        push_byte(8'hA3, 1, 1'b0);
        push_byte(8'hA4, 1, 1'b0);
        rd(A_STAT, 32'h0000_0040, 1'b1);
        rd(A_STAT, 32'h0000_0030, 1'b1);
        @(posedge clk);
        #3;
        rd_req = 1'b0; mem_adr = '0; tx_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midrst_din", din, 32'h0);
        check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        clr_mark = '0;
        rd(A_STAT, 32'h0000_0002, 1'b0);
        idle(3, 1'b0);

        check("exp_q_left", 32'(exp_q.size()), 32'h0);
        check("tx_q_left", 32'(tx_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
